// File: rtl/prog_loader_if.sv
// Valid/ready word stream feeding the program loader.
// The host drives words through the master modport; the loader consumes them through the slave modport.
`timescale 1ns/1ps
interface prog_loader_if #(
   parameter int DATA_W = 32
) ();
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses header/payload words and writes them into imem or dmem, holding the core until an end marker.
// Optional macro LOADER_CHECKSUM_EN adds a per-segment XOR checksum word and the CHECK state.
`timescale 1ns/1ps
module prog_loader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 7,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   prog_loader_if.slave      s,
   output logic [DATA_W-1:0] instruction,
   output logic [ADDR_W-1:0] instructionAddress,
   output logic              writeEnable,
   output logic [DATA_W-1:0] data,
   output logic [ADDR_W-1:0] dataAddress,
   output logic              dataWriteEnable,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);
   localparam int SUM_W = ADDR_W + LEN_W + 1;
   localparam logic [SUM_W-1:0]  LIMIT      = SUM_W'(1) << ADDR_W;
   // Bits that belong to a defined header field; everything else is reserved.
   localparam logic [DATA_W-1:0] FIELD_MASK = (DATA_W'(1) << (DATA_W - 1))
                                            | ((DATA_W'(1) << (LEN_W + ADDR_W)) - DATA_W'(1));

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_LOAD, ST_CHECK, ST_DONE, ST_FAIL} state_t;
   logic [DATA_W-1:0] xor_reg;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_LOAD, ST_DONE, ST_FAIL} state_t;
`endif

   state_t            state_reg;
   logic              ready_reg;
   logic              target_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [LEN_W-1:0]  remaining_reg;

   logic              accept;
   logic              hdr_target;
   logic [ADDR_W-1:0] hdr_base;
   logic [LEN_W-1:0]  hdr_len;
   logic [SUM_W-1:0]  hdr_end;
   logic              hdr_rsv;
   logic              hdr_ovf;

   assign s.s_ready  = ready_reg;
   assign accept     = s.s_valid & ready_reg;
   assign hdr_target = s.s_data[DATA_W-1];
   assign hdr_base   = s.s_data[LEN_W +: ADDR_W];
   assign hdr_len    = s.s_data[LEN_W-1:0];
   assign hdr_rsv    = |(s.s_data & ~FIELD_MASK);
   // Wide enough that base+N can never wrap before the compare.
   assign hdr_end    = SUM_W'(hdr_base) + SUM_W'(hdr_len);
   assign hdr_ovf    = hdr_end > LIMIT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg          <= ST_IDLE;
         ready_reg          <= 1'b0;
         target_reg         <= 1'b0;
         addr_reg           <= '0;
         remaining_reg      <= '0;
         instruction        <= '0;
         instructionAddress <= '0;
         writeEnable        <= 1'b0;
         data               <= '0;
         dataAddress        <= '0;
         dataWriteEnable    <= 1'b0;
         cpu_hold           <= 1'b1;
         done               <= 1'b0;
         error              <= 1'b0;
         word_count         <= '0;
`ifdef LOADER_CHECKSUM_EN
         xor_reg            <= '0;
`endif
      end else begin
         writeEnable     <= 1'b0;
         dataWriteEnable <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_DONE, ST_FAIL: begin
               if (start) begin
                  state_reg  <= ST_HEADER;
                  ready_reg  <= 1'b1;
                  cpu_hold   <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  word_count <= '0;
               end
            end
            ST_HEADER: begin
               if (accept) begin
                  if (hdr_len == '0) begin
                     state_reg <= ST_DONE;
                     ready_reg <= 1'b0;
                     done      <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else if (hdr_ovf || hdr_rsv) begin
                     state_reg <= ST_FAIL;
                     ready_reg <= 1'b0;
                     error     <= 1'b1;
                  end else begin
                     state_reg     <= ST_LOAD;
                     target_reg    <= hdr_target;
                     addr_reg      <= hdr_base;
                     remaining_reg <= hdr_len;
`ifdef LOADER_CHECKSUM_EN
                     xor_reg       <= '0;
`endif
                  end
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  if (target_reg) begin
                     data            <= s.s_data;
                     dataAddress     <= addr_reg;
                     dataWriteEnable <= 1'b1;
                  end else begin
                     instruction        <= s.s_data;
                     instructionAddress <= addr_reg;
                     writeEnable        <= 1'b1;
                  end
                  word_count    <= word_count + 1'b1;
                  addr_reg      <= addr_reg + 1'b1;
                  remaining_reg <= remaining_reg - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  xor_reg       <= xor_reg ^ s.s_data;
                  if (remaining_reg == LEN_W'(1)) state_reg <= ST_CHECK;
`else
                  if (remaining_reg == LEN_W'(1)) state_reg <= ST_HEADER;
`endif
               end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (accept) begin
                  if (s.s_data == xor_reg) begin
                     state_reg <= ST_HEADER;
                  end else begin
                     state_reg <= ST_FAIL;
                     ready_reg <= 1'b0;
                     error     <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state_reg <= ST_IDLE;
               ready_reg <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_prog_loader.sv
// Randomised scoreboard bench for prog_loader: a segment-level reference model predicts every memory write
// and the final done/error/word_count; a monitor compares each strobe against the expected-write queue.
`timescale 1ns/1ps
module tb_prog_loader;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 7;
   localparam int LEN_W  = 16;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic [DATA_W-1:0] instruction;
   logic [ADDR_W-1:0] instructionAddress;
   logic              writeEnable;
   logic [DATA_W-1:0] data;
   logic [ADDR_W-1:0] dataAddress;
   logic              dataWriteEnable;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   word_count;

   prog_loader_if #(.DATA_W(DATA_W)) bus ();

   prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s(bus.slave),
      .instruction(instruction), .instructionAddress(instructionAddress), .writeEnable(writeEnable),
      .data(data), .dataAddress(dataAddress), .dataWriteEnable(dataWriteEnable),
      .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit                tgt;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] d;
      int                wc;
   } wr_t;

   wr_t               sb[$];
   logic [DATA_W-1:0] stim[$];
   logic [DATA_W-1:0] cks;
   int                checks = 0;
   int                errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe must match the next expected write; the other memory's outputs must hold.
   initial begin
      wr_t               e;
      logic [DATA_W-1:0] last_i_d = '0, last_d_d = '0;
      logic [ADDR_W-1:0] last_i_a = '0, last_d_a = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            last_i_d = '0; last_d_d = '0; last_i_a = '0; last_d_a = '0;
         end else if (writeEnable || dataWriteEnable) begin
            chk("strobe_onehot", writeEnable & dataWriteEnable, 0);
            if (sb.size() == 0) begin
               chk("unexpected_strobe", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("strobe_target", dataWriteEnable, e.tgt);
               if (e.tgt) begin
                  chk("dmem_data", data, e.d);
                  chk("dmem_addr", dataAddress, e.addr);
                  chk("imem_data_hold", instruction, last_i_d);
                  chk("imem_addr_hold", instructionAddress, last_i_a);
                  last_d_d = e.d; last_d_a = e.addr;
               end else begin
                  chk("imem_data", instruction, e.d);
                  chk("imem_addr", instructionAddress, e.addr);
                  chk("dmem_data_hold", data, last_d_d);
                  chk("dmem_addr_hold", dataAddress, last_d_a);
                  last_i_d = e.d; last_i_a = e.addr;
               end
               chk("word_count_on_write", word_count, e.wc);
               $display("WRITE %s addr=%0d data=%08h wc=%0d", e.tgt ? "dmem" : "imem", e.addr, e.d, e.wc);
            end
         end
      end
   end

   // Reference model: walks the stream segment by segment and predicts writes plus final status.
   task automatic model(input logic [DATA_W-1:0] w[$], output int used, output bit exp_done,
                        output bit exp_err, output int exp_wc);
      int                i = 0;
      int                n, base;
      logic [DATA_W-1:0] h, x;
      wr_t               e;
      exp_done = 0;
      exp_err  = 0;
      exp_wc   = 0;
      while (i < w.size()) begin
         h = w[i]; i++;
         n = int'(h[15:0]);
         base = int'(h[22:16]);
         if (n == 0) begin exp_done = 1; break; end
         if (base + n > DEPTH || h[30:23] != 0) begin exp_err = 1; break; end
         x = '0;
         for (int k = 0; k < n; k++) begin
            exp_wc++;
            e.tgt = h[31]; e.addr = ADDR_W'(base + k); e.d = w[i]; e.wc = exp_wc;
            sb.push_back(e);
            x ^= w[i];
            i++;
         end
`ifdef LOADER_CHECKSUM_EN
         i++;
         if (w[i-1] != x) begin exp_err = 1; break; end
`endif
      end
      used = i;
   endtask

   task automatic push_hdr(input bit tgt, input int base, input int n);
      stim.push_back({tgt, 8'h00, ADDR_W'(base), LEN_W'(n)});
      cks = '0;
   endtask

   task automatic push_word(input logic [DATA_W-1:0] w);
      stim.push_back(w);
      cks ^= w;
   endtask

   task automatic push_cks(input logic [DATA_W-1:0] corrupt);
`ifdef LOADER_CHECKSUM_EN
      stim.push_back(cks ^ corrupt);
`else
      cks = cks ^ corrupt;
`endif
   endtask

   task automatic start_pulse();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w, input int gap, output bit ok);
      int n = 0;
      for (int i = 0; i < gap; i++) begin @(negedge clk); bus.s_valid = 1'b0; end
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      while (!bus.s_ready && n < 50) begin @(negedge clk); n++; end
      ok = bus.s_ready;
      if (ok) @(posedge clk);
      else begin
         bus.s_valid = 1'b0;
         chk("s_ready_wait", 0, 1);
      end
   endtask

   task automatic run_load(input string tag, input logic [DATA_W-1:0] w[$], input int gap, input int ign_idx);
      int used, ewc, n, g;
      bit ed, ee, ok;
      model(w, used, ed, ee, ewc);
      start_pulse();
      chk({tag, "_start_done"}, done, 0);
      chk({tag, "_start_error"}, error, 0);
      chk({tag, "_start_hold"}, cpu_hold, 1);
      chk({tag, "_start_wc"}, word_count, 0);
      chk({tag, "_start_ready"}, bus.s_ready, 1);
      for (int j = 0; j < used; j++) begin
         if (j == ign_idx) begin
            @(negedge clk); bus.s_valid = 1'b0; start = 1'b1;
            @(negedge clk); start = 1'b0;
         end
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         send_word(w[j], g, ok);
         if (!ok) break;
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
      chk({tag, "_drain"}, sb.size(), 0);
      sb.delete();
      @(negedge clk);
      chk({tag, "_done"}, done, ed);
      chk({tag, "_error"}, error, ee);
      chk({tag, "_hold"}, cpu_hold, !ed);
      chk({tag, "_ready"}, bus.s_ready, 0);
      chk({tag, "_wc"}, word_count, ewc);
      $display("LOAD %s words=%0d exp_done=%0d exp_error=%0d exp_wc=%0d", tag, used, ed, ee, ewc);
   endtask

   task automatic gen_random();
      int nseg, kind, n, base;
      bit tgt;
      logic [DATA_W-1:0] h;
      stim.delete();
      nseg = int'($urandom_range(1, 3));
      for (int s = 0; s < nseg; s++) begin
         kind = int'($urandom_range(0, 9));
         tgt  = 1'($urandom_range(0, 1));
         n    = int'($urandom_range(1, 4));
         if (kind == 0) begin
            n    = int'($urandom_range(2, 4));
            base = int'($urandom_range(DEPTH - n + 1, DEPTH - 1));
         end else begin
            base = int'($urandom_range(0, DEPTH - n));
         end
         push_hdr(tgt, base, n);
         if (kind == 1) begin
            h = stim.pop_back();
            h[$urandom_range(23, 30)] = 1'b1;
            stim.push_back(h);
         end
         for (int k = 0; k < n; k++) push_word($urandom());
         push_cks((kind == 2) ? 32'h1 : 32'h0);
      end
      stim.push_back('0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      wr_t e;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_we", writeEnable, 0);
      chk("rst_dwe", dataWriteEnable, 0);
      chk("rst_instr", instruction, 0);
      chk("rst_iaddr", instructionAddress, 0);
      chk("rst_data", data, 0);
      chk("rst_daddr", dataAddress, 0);
      chk("rst_ready", bus.s_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_wc", word_count, 0);
      chk("rst_hold", cpu_hold, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      stim.delete();
      push_hdr(0, 0, 3);
      push_word(32'h8C01_0000); push_word(32'h2042_0003); push_word(32'h1401_003F);
      push_cks(0);
      stim.push_back('0);
      run_load("imem", stim, 0, -1);

      stim.delete();
      push_hdr(1, 8'h40, 2); push_word(32'd12); push_word(32'd7); push_cks(0);
      push_hdr(0, 66, 1); push_word(32'hAC21_0001); push_cks(0);
      stim.push_back('0);
      run_load("mixed", stim, 1, -1);

      stim.delete();
      push_hdr(0, 126, 3); push_word(32'h1); push_word(32'h2); push_word(32'h3); push_cks(0);
      stim.push_back('0);
      run_load("overflow", stim, 0, -1);

      stim.delete();
      push_hdr(0, 126, 2); push_word(32'hDEAD_0001); push_word(32'hDEAD_0002); push_cks(0);
      stim.push_back('0);
      run_load("top_edge", stim, 0, -1);

      stim.delete();
      push_hdr(1, 3, 2); push_word(32'h11); push_word(32'h22); push_cks(0);
      stim.push_back('0);
      stim[0][25] = 1'b1;
      run_load("reserved", stim, 0, -1);

      stim.delete();
      push_hdr(0, 5, 3); push_word(32'hA1); push_word(32'hA2); push_word(32'hA3); push_cks(0);
      stim.push_back('0);
      run_load("ignored_start", stim, 0, 2);

`ifdef LOADER_CHECKSUM_EN
      stim.delete();
      push_hdr(1, 20, 2); push_word(32'h5); push_word(32'h3); push_cks(0);
      stim.push_back('0);
      run_load("cks_good", stim, 0, -1);
      stim.delete();
      push_hdr(1, 20, 2); push_word(32'h5); push_word(32'h3); push_cks(32'h1);
      stim.push_back('0);
      run_load("cks_bad", stim, 0, -1);
`endif

      // Reset in the middle of a 3-word segment, after the first write.
      start_pulse();
      e.tgt = 0; e.addr = 7'd10; e.d = 32'hAAAA_5555; e.wc = 1;
      sb.push_back(e);
      send_word({1'b0, 8'h00, 7'd10, 16'd3}, 0, ok);
      send_word(32'hAAAA_5555, 0, ok);
      @(negedge clk);
      bus.s_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h1234_5678;
      #1;
      chk("midrst_we", writeEnable, 0);
      chk("midrst_instr", instruction, 0);
      chk("midrst_iaddr", instructionAddress, 0);
      chk("midrst_ready", bus.s_ready, 0);
      chk("midrst_hold", cpu_hold, 1);
      chk("midrst_wc", word_count, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bus.s_valid = 1'b0;
      chk("midrst_drain", sb.size(), 0);
      sb.delete();
      $display("RESET mid-load applied");

      stim.delete();
      push_hdr(0, 10, 3); push_word(32'hB1); push_word(32'hB2); push_word(32'hB3); push_cks(0);
      stim.push_back('0);
      run_load("after_reset", stim, 0, -1);

      for (int r = 0; r < 25; r++) begin
         gen_random();
         run_load($sformatf("rand%0d", r), stim, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
# prog_loader

Parametrised program/data loader that boots the MIPS core. It accepts a valid/ready word stream of segment headers and payload words, and writes each payload word into instruction memory or data memory at auto-incrementing addresses. It holds the core in stall until an end marker is received. It sits between the host/bench stimulus port and the `main` memory write ports, and it replaces hand-driven instruction/data/address/writeEnable sequencing.

## Interface
Parameters:
- `DATA_W`, 32: word width of stream and memories.
- `ADDR_W`, 7: address width of both memories; memory depth is 2**ADDR_W.
- `LEN_W`, 16: header length field width; `LEN_W` ≤ `DATA_W`-`ADDR_W`-1.

Ports:
- `clk`, input, 1: single clock; all logic rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: pulse; begins a load from IDLE, DONE or FAIL.
- `s_valid`, input, 1: stream word valid.
- `s_ready`, output, 1: loader accepts the word this cycle.
- `s_data`, input, `DATA_W`: stream word.
- `instruction`, output, `DATA_W`: imem write data.
- `instructionAddress`, output, `ADDR_W`: imem write address.
- `writeEnable`, output, 1: imem write strobe, one cycle per word.
- `data`, output, `DATA_W`: dmem write data.
- `dataAddress`, output, `ADDR_W`: dmem write address.
- `dataWriteEnable`, output, 1: dmem write strobe.
- `cpu_hold`, output, 1: stalls the core while high.
- `done`, output, 1: level; load completed cleanly.
- `error`, output, 1: sticky; load aborted.
- `word_count`, output, `ADDR_W`+1: total payload words written since `start`.

## Operation
Header word fields:
- bit `DATA_W`-1: target; 0 selects imem, 1 selects dmem.
- bits [`LEN_W`+`ADDR_W`-1:`LEN_W`]: base address.
- bits [`LEN_W`-1:0]: length N.
- All other bits must be 0; a nonzero value there is an error.
- N=0 is the end marker.

States:
- IDLE: `s_ready`=0, `cpu_hold`=1. `start` → HEADER; clears `done`, `error` and `word_count`.
- HEADER: `s_ready`=1. On accept:
  - N=0 → DONE.
  - base+N > 2**ADDR_W, computed at `ADDR_W`+1 bits plus `LEN_W` so it cannot wrap, → FAIL.
  - Reserved bits nonzero → FAIL.
  - Otherwise latch target, address=base and remaining=N, then → LOAD.
- LOAD: `s_ready`=1. Each accepted word is written to the target at the current address. Address then increments and remaining decrements. When remaining reaches 0: → CHECK if `LOADER_CHECKSUM_EN` is defined, else → HEADER.
- CHECK (macro only): accept one word and compare it with the running XOR of the segment payload. Match → HEADER; mismatch → FAIL.
- DONE: `done`=1, `cpu_hold`=0, `s_ready`=0. `start` re-enters HEADER and reasserts `cpu_hold`.
- FAIL: `error`=1, `cpu_hold`=1, `s_ready`=0. Only `start` or reset leaves this state.

Rules:
- Words written before a failure are not rolled back.
- `start` in HEADER, LOAD or CHECK is ignored.
- The address never wraps, because of the overflow check in HEADER.
- The write-data and address outputs of the non-selected memory hold their last value. Only one strobe is high per cycle.

## Timing
- Reset values: all strobes 0, all data and address outputs 0, `s_ready`=0, `done`=0, `error`=0, `word_count`=0, `cpu_hold`=1, state IDLE.
- Reset is asynchronous. Asserting it mid-load forces the reset values immediately, and no further strobe occurs.
- A word is accepted when `s_valid` and `s_ready` are both high at a rising edge.
- Write latency is 1 cycle. Strobe, address and data are registered, so they are valid the cycle after acceptance, for exactly one cycle.
- Back-to-back words give one write per cycle; throughput is 1 word/cycle.
- `s_ready` is a registered function of state only, so there is no combinational path from `s_valid`.
- DONE/FAIL are entered in the cycle after the deciding word is accepted. `cpu_hold` falls in that same cycle, after the last strobe has already fired.
- `word_count` increments with each strobe.

## Configuration
- `LOADER_CHECKSUM_EN` defined: each nonempty segment is followed by one checksum word, the XOR of its N payload words. A mismatch → FAIL. A running XOR register is compiled in.
- `LOADER_CHECKSUM_EN` undefined: there is no CHECK state, no checksum word and no XOR register. The header goes straight to the next HEADER after N words.

## Test plan
- Imem load:
  - Stimulus: `start`, then header 0x0000_0003 (imem, base 0, N=3), then words 0x8C01_0000, 0x2042_0003, 0x1401_003F, then end marker 0.
  - Required response: `writeEnable` pulses at addresses 0, 1, 2 with those words; `done`=1; `cpu_hold`=0; `word_count`=3.
- Mixed segments with stalls:
  - Stimulus: dmem header base 0x40, N=2, words 12 and 7; then imem header base 66, N=1, word 0xAC21_0001; `s_valid` toggled every other cycle.
  - Required response: `dataWriteEnable` at 0x40 and 0x41; `writeEnable` at 66; no strobe during cycles without a handshake.
- Overflow:
  - Stimulus: header imem base 126, N=3.
  - Required response: no strobe; `error`=1; `cpu_hold`=1; `s_ready`=0.
  - Follow-up: `start` clears `error` and a valid reload then succeeds.
- Reset mid-load:
  - Stimulus: assert `rst_n`=0 after 1 of 3 words.
  - Required response: all outputs take reset values asynchronously; the following load restarts from IDLE.
- Checksum (macro defined):
  - Stimulus: N=2 with words 0x5 and 0x3; checksum 0x6 → next HEADER. Repeat with checksum 0x7.
  - Required response: 0x6 is accepted; 0x7 → `error`=1 after both writes have occurred.
- Ignored start:
  - Stimulus: `start` pulse during LOAD.
  - Required response: no state change, and `word_count` is unaffected.
